// File: rtl/debounce_bank_pkg.sv
// Shared defaults, channel pulse type and a constant clog2 helper for the
// debounce bank.
package debounce_bank_pkg;

  localparam int DEFAULT_DELAY       = 5;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_LONG_DELAY  = 0;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_pulse_t;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/debounce_bank_channel.sv
// One debounced switch: synchroniser, stability counter, accepted level,
// edge pulses and optional long-press detector.
module debounce_channel
  import debounce_bank_pkg::*;
#(
  parameter int   DELAY       = DEFAULT_DELAY,
  parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int   LONG_DELAY  = DEFAULT_LONG_DELAY,
  parameter logic RESET_BIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic change_next
);

  localparam int                CNT_W    = clog2(DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DELAY);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   level_reg;
  logic                   level_next;
  logic                   rise_reg;
  logic                   fall_reg;
  logic                   s;
  logic                   differ;
  logic                   toggle;
  edge_pulse_t            pulse_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= {SYNC_STAGES{RESET_BIT}};
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_bit};
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // The DELAY-th consecutive differing sample flips the level directly.
  always_comb begin
    differ          = s ^ level_reg;
    toggle          = differ && (cnt_reg == CNT_LAST);
    cnt_next        = '0;
    if (differ && !toggle) begin
      cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    end
    level_next      = level_reg ^ toggle;
    pulse_next.rise = toggle & ~level_reg;
    pulse_next.fall = toggle & level_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      level_reg <= RESET_BIT;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      rise_reg  <= pulse_next.rise;
      fall_reg  <= pulse_next.fall;
    end
  end

  assign level       = level_reg;
  assign rise        = rise_reg;
  assign fall        = fall_reg;
  assign change_next = pulse_next.rise | pulse_next.fall;

  generate
    if (LONG_DELAY > 0) begin : g_long
      localparam int               LP_W    = clog2(LONG_DELAY + 1);
      localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_DELAY - 1);

      logic [LP_W-1:0] lp_cnt_reg;
      logic            armed_reg;
      logic            long_reg;

      // Armed on each rise; disarmed after firing or by a fall, so a press
      // fires at most once and never alongside its own fall.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lp_cnt_reg <= '0;
          armed_reg  <= 1'b0;
          long_reg   <= 1'b0;
        end else begin
          long_reg <= 1'b0;
          if (pulse_next.rise) begin
            lp_cnt_reg <= '0;
            armed_reg  <= 1'b1;
          end else if (pulse_next.fall) begin
            armed_reg <= 1'b0;
          end else if (level_reg && armed_reg) begin
            if (lp_cnt_reg == LP_LAST) begin
              long_reg  <= 1'b1;
              armed_reg <= 1'b0;
            end else begin
              lp_cnt_reg <= lp_cnt_reg + 1'b1;
            end
          end
        end
      end

      assign long_press = long_reg;
    end else begin : g_no_long
      assign long_press = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/debounce_bank.sv
// Bank of WIDTH independent switch debouncers with edge, long-press and
// any-change reporting.
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DELAY       = DEFAULT_DELAY,
  parameter int               SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int               LONG_DELAY  = DEFAULT_LONG_DELAY,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_switch,
  output logic [WIDTH-1:0] out_switch,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] long_press,
  output logic             any_change
);

  logic [WIDTH-1:0] change_next;
  logic             any_change_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      debounce_channel #(
        .DELAY      (DELAY),
        .SYNC_STAGES(SYNC_STAGES),
        .LONG_DELAY (LONG_DELAY),
        .RESET_BIT  (RESET_VAL[gi])
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .in_bit     (in_switch[gi]),
        .level      (out_switch[gi]),
        .rise       (rise[gi]),
        .fall       (fall[gi]),
        .long_press (long_press[gi]),
        .change_next(change_next[gi])
      );
    end
  endgenerate

  // Registered from the channels' next-pulse terms so it lines up with rise/fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_change_reg <= 1'b0;
    else     any_change_reg <= |change_next;
  end

  assign any_change = any_change_reg;

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of independent switch channels (1..32).
REQ-002 SHALL have parameter DELAY, default 5, consecutive stable cycles required to accept a level change (1..65535).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-004 SHALL have parameter LONG_DELAY, default 0, cycles of accepted high before long_press fires; 0 disables long_press.
REQ-005 SHALL have parameter RESET_VAL, default all-zero (WIDTH bits), out_switch and synchroniser value after reset.
REQ-006 clk  input  1  sole clock; all state is on its rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 in_switch  input  WIDTH  raw asynchronous switch levels.
REQ-009 out_switch  output  WIDTH  debounced levels, registered.
REQ-010 rise  output  WIDTH  one-cycle pulse when out_switch goes 0->1.
REQ-011 fall  output  WIDTH  one-cycle pulse when out_switch goes 1->0.
REQ-012 long_press  output  WIDTH  one-cycle pulse after out_switch has been high for LONG_DELAY cycles.
REQ-013 any_change  output  1  registered OR of rise|fall, same cycle as those pulses.

Function
REQ-014 Each in_switch bit SHALL pass through SYNC_STAGES flops before any other logic; the last stage is "s".
REQ-015 Per channel, a stability counter SHALL clear in any cycle where s equals out_switch, and increment in any cycle where they differ.
REQ-016 out_switch SHALL toggle in the cycle after the counter has counted DELAY differing cycles; the counter clears on that toggle.
REQ-017 Latency from an in_switch change (setup-met) to out_switch change SHALL be exactly SYNC_STAGES+DELAY cycles.
REQ-018 A pulse on s shorter than DELAY cycles SHALL never change out_switch (no runt output).
REQ-019 A glitch back to the accepted level SHALL restart the count from zero; counts do not accumulate across glitches.
REQ-020 Counter width SHALL be clog2(DELAY+1) and SHALL saturate, never wrap.
REQ-021 rise/fall SHALL assert in the same cycle out_switch first shows the new level, for one cycle only.
REQ-022 long_press counter SHALL start at the rise cycle, fire once at LONG_DELAY high cycles, and not refire until a fall then a new rise.
REQ-023 A fall before LONG_DELAY SHALL cancel long_press for that press; long_press and fall are never asserted together.
REQ-024 Channels SHALL be fully independent; simultaneous changes on several channels produce simultaneous pulses.
REQ-025 With LONG_DELAY=0, long_press SHALL be tied low and its counter not synthesised.

Reset
REQ-026 rst SHALL asynchronously force synchronisers and out_switch to RESET_VAL, all counters to 0, rise/fall/long_press/any_change to 0.
REQ-027 After rst deasserts, no rise/fall pulse SHALL occur unless in_switch differs from RESET_VAL for DELAY cycles.
REQ-028 Reset mid-count SHALL discard the partial count; no pulse on the reset-release cycle.

Structure
REQ-029 One sub-module debounce_channel (one bit: synchroniser, counter, level, edge, long-press), instanced WIDTH times via generate.
REQ-030 Shared package/include SHALL hold default DELAY, SYNC_STAGES, LONG_DELAY and a clog2 function; no per-module copies.
REQ-031 No combinational path from in_switch to any output.

Verification
REQ-032 WIDTH=5, DELAY=5, SYNC=2: all inputs 0->1 -> out_switch=5'h1F exactly 7 cycles later, rise=5'h1F for one cycle, any_change=1.
REQ-033 Runt: ch0 high 3 cycles then low -> out_switch, rise, fall stay 0 throughout (continuous monitor).
REQ-034 Glitch: ch1 high 4 cycles, low 1, high 5 -> out_switch[1] rises 5 cycles after the second high on s, not earlier.
REQ-035 LONG_DELAY=10: ch2 held high 20 cycles -> long_press[2] one pulse 10 cycles after rise[2]; held 6 then released -> no long_press, fall[2] pulses.
REQ-036 rst asserted mid-count (ch3 at count 3) -> outputs immediately 0/RESET_VAL; after release with input still high, out_switch rises after full 7 cycles.
REQ-037 Random toggling on 8 channels, 10k cycles -> scoreboard model matches out_switch/rise/fall every cycle; any_change == |(rise|fall).
